// File: rtl/rans_pkg.sv
// Shared types and defaults for the rANS byte packer: byte and word geometry,
// the word and keep-mask types, and the packer state encoding.
package rans_pkg;

  localparam int SYMBOL_WIDTH = 8;
  localparam int WORD_BYTES   = 4;

  typedef logic [WORD_BYTES*SYMBOL_WIDTH-1:0] word_t;
  typedef logic [WORD_BYTES-1:0]              keep_t;

  typedef enum logic {
    ACCUM,
    FLUSH_PEND
  } state_e;

endpackage

// File: rtl/rans_word_fifo.sv
// Synchronous word FIFO for the packer output. The head comes straight from the
// storage registers and reads as zero while the FIFO is empty.
module rans_word_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             empty, full, pop, wr_en;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign pop     = pop_i && !empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign wr_en   = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;
  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/rans_byte_packer.sv
// Packs 0-2 encoder bytes per cycle into little-endian words, with end-of-stream
// flush producing a last-marked (possibly partial or empty) word.
module rans_byte_packer #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int WORD_BYTES   = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [1:0]                         valid_i,
  input  logic [2*SYMBOL_WIDTH-1:0]          enc_i,
  input  logic                               flush_i,
  output logic                               m_tvalid_o,
  input  logic                               m_tready_i,
  output logic [WORD_BYTES*SYMBOL_WIDTH-1:0] m_tdata_o,
  output logic [WORD_BYTES-1:0]              m_tkeep_o,
  output logic                               m_tlast_o,
  output logic                               overflow_o,
  output logic                               protocol_err_o
);

  import rans_pkg::*;

  localparam int FILL_W = $clog2(WORD_BYTES);
  localparam int WORD_W = WORD_BYTES * SYMBOL_WIDTH;
  localparam int PAY_W  = WORD_W + WORD_BYTES + 1;

  state_e                                  state_q, state_d;
  logic [FILL_W-1:0]                       fill_q, fill_d;
  logic [WORD_BYTES-1:0][SYMBOL_WIDTH-1:0] acc_q, acc_d;
  logic                                    ovf_q, perr_q, perr_set, drop;

  logic                                    push, push_last;
  logic [WORD_W-1:0]                       push_data;
  logic [WORD_BYTES-1:0]                   push_keep;
  logic [WORD_BYTES:0][SYMBOL_WIDTH-1:0]   ext;
  logic [PAY_W-1:0]                        head;
  int                                      n, total, fill_int;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    acc_d     = acc_q;
    push      = 1'b0;
    push_data = '0;
    push_keep = '0;
    push_last = 1'b0;
    perr_set  = (valid_i == 2'b10);
    n         = 0;
    ext       = '0;
    fill_int  = int'(fill_q);
    total     = fill_int;

    case (state_q)
      ACCUM: begin
        if (valid_i == 2'b01)      n = 1;
        else if (valid_i == 2'b11) n = 2;
        // One spare lane catches the byte that spills past a full word.
        ext[WORD_BYTES-1:0] = acc_q;
        for (int l = 0; l <= WORD_BYTES; l++) begin
          if (n >= 1 && l == fill_int)     ext[l] = enc_i[SYMBOL_WIDTH-1:0];
          if (n == 2 && l == fill_int + 1) ext[l] = enc_i[2*SYMBOL_WIDTH-1:SYMBOL_WIDTH];
        end
        total = fill_int + n;

        if (total >= WORD_BYTES) begin
          push      = 1'b1;
          push_data = ext[WORD_BYTES-1:0];
          push_keep = '1;
          acc_d     = '0;
          acc_d[0]  = ext[WORD_BYTES];
          fill_d    = FILL_W'(total - WORD_BYTES);
          if (flush_i) begin
            if (total > WORD_BYTES) state_d = FLUSH_PEND;
            else                    push_last = 1'b1;
          end
        end else if (flush_i) begin
          push      = 1'b1;
          push_data = ext[WORD_BYTES-1:0];
          for (int l = 0; l < WORD_BYTES; l++) push_keep[l] = (l < total);
          push_last = 1'b1;
          acc_d     = '0;
          fill_d    = '0;
        end else begin
          acc_d  = ext[WORD_BYTES-1:0];
          fill_d = FILL_W'(total);
        end
      end

      FLUSH_PEND: begin
        // Bytes here break the upstream contract and are dropped.
        if (valid_i != 2'b00) perr_set = 1'b1;
        push      = 1'b1;
        push_data = acc_q;
        for (int l = 0; l < WORD_BYTES; l++) push_keep[l] = (l < fill_int);
        push_last = 1'b1;
        acc_d     = '0;
        fill_d    = '0;
        state_d   = ACCUM;
      end

      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      fill_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      if (drop)     ovf_q  <= 1'b1;
      if (perr_set) perr_q <= 1'b1;
    end
  end

  rans_word_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  ({push_last, push_keep, push_data}),
    .pop_i   (m_tready_i),
    .valid_o (m_tvalid_o),
    .data_o  (head),
    .drop_o  (drop)
  );

  assign m_tdata_o      = head[WORD_W-1:0];
  assign m_tkeep_o      = head[WORD_W +: WORD_BYTES];
  assign m_tlast_o      = head[PAY_W-1];
  assign overflow_o     = ovf_q;
  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_rans_byte_packer.sv
// Testbench for rans_byte_packer: directed scenarios plus a randomized stream
// checked against a byte-queue reference model.
module tb_rans_byte_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, tvalid, tready, tlast, ovf, perr;
  logic [1:0]  valid;
  logic [15:0] enc;
  logic [31:0] tdata;
  logic [3:0]  tkeep;

  always #5 clk = ~clk;

  rans_byte_packer #(.SYMBOL_WIDTH(8), .WORD_BYTES(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (valid),
    .enc_i          (enc),
    .flush_i        (flush),
    .m_tvalid_o     (tvalid),
    .m_tready_i     (tready),
    .m_tdata_o      (tdata),
    .m_tkeep_o      (tkeep),
    .m_tlast_o      (tlast),
    .overflow_o     (ovf),
    .protocol_err_o (perr)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } wrd_t;

  wrd_t       mq[$];
  logic [7:0] pend[$];
  bit         m_fp, m_ovf, m_perr;
  int         total = 0;
  int         bad = 0;

  function automatic wrd_t take(int cnt);
    wrd_t w;
    w.d = '0; w.k = '0; w.l = 1'b0;
    for (int j = 0; j < cnt; j++) begin
      w.d[8*j +: 8] = pend.pop_front();
      w.k[j] = 1'b1;
    end
    return w;
  endfunction

  task automatic model_reset();
    mq.delete(); pend.delete();
    m_fp = 0; m_ovf = 0; m_perr = 0;
  endtask

  task automatic model_step(input logic [1:0] v, input logic [15:0] e, input logic f, input logic r);
    wrd_t w;
    bit   have = 0;
    if (mq.size() > 0 && r) void'(mq.pop_front());
    if (m_fp) begin
      if (v != 2'b00) m_perr = 1;
      w = take(pend.size()); w.l = 1'b1; have = 1; m_fp = 0;
    end else begin
      if (v == 2'b10) m_perr = 1;
      if (v == 2'b01 || v == 2'b11) pend.push_back(e[7:0]);
      if (v == 2'b11) pend.push_back(e[15:8]);
      if (pend.size() >= 4) begin
        w = take(4);
        w.l = f && (pend.size() == 0);
        have = 1;
        if (f && pend.size() > 0) m_fp = 1;
      end else if (f) begin
        w = take(pend.size()); w.l = 1'b1; have = 1;
      end
    end
    if (have) begin
      if (mq.size() < DEPTH) mq.push_back(w);
      else m_ovf = 1;
    end
  endtask

  task automatic cycle(input logic [1:0] v, input logic [15:0] e, input logic f, input logic r);
    valid = v; enc = e; flush = f; tready = r;
    @(posedge clk);
    model_step(v, e, f, r);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; valid = 0; enc = 0; flush = 0; tready = 0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({tvalid, tdata, tkeep, tlast} !== 38'h0) begin
      bad++; $display("FAIL reset_outputs: got v=%b d=%h k=%h l=%b want all zero", tvalid, tdata, tkeep, tlast);
    end
    total++;
    if ({ovf, perr} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got ovf=%b perr=%b want 0 0", ovf, perr);
    end
  endtask

  task automatic test_single_bytes();
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(2'b01, {8'h00, b[i]}, 1'b0, 1'b1);
      total++;
      if (tvalid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0 at byte %0d", tvalid, i); end
    end
    cycle(2'b01, {8'h00, b[3]}, 1'b0, 1'b1);
    total++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h44332211, 4'hF, 1'b0}) begin
      bad++; $display("FAIL single_word: got v=%b d=%h k=%h l=%b want v=1 d=44332211 k=f l=0", tvalid, tdata, tkeep, tlast);
    end
    cycle(2'b00, 16'h0, 1'b0, 1'b1);
    total++;
    if (tvalid !== 1'b0) begin bad++; $display("FAIL single_drain: got v=%b want 0", tvalid); end
  endtask

  task automatic test_pairs();
    do_reset();
    cycle(2'b11, 16'h2211, 1'b0, 1'b1);
    cycle(2'b11, 16'h4433, 1'b0, 1'b1);
    total++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h44332211, 4'hF, 1'b0}) begin
      bad++; $display("FAIL pairs_word: got v=%b d=%h k=%h l=%b want v=1 d=44332211 k=f l=0", tvalid, tdata, tkeep, tlast);
    end
    cycle(2'b11, 16'h6655, 1'b0, 1'b1);
    total++;
    if (tvalid !== 1'b0) begin bad++; $display("FAIL pairs_no_word: got v=%b want 0", tvalid); end
    cycle(2'b00, 16'h0, 1'b1, 1'b1);
    total++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h00006655, 4'h3, 1'b1}) begin
      bad++; $display("FAIL pairs_remainder: got v=%b d=%h k=%h l=%b want v=1 d=00006655 k=3 l=1", tvalid, tdata, tkeep, tlast);
    end
  endtask

  task automatic test_flush_split();
    do_reset();
    cycle(2'b01, 16'h00AA, 1'b0, 1'b1);
    cycle(2'b01, 16'h00BB, 1'b0, 1'b1);
    cycle(2'b01, 16'h00CC, 1'b0, 1'b1);
    cycle(2'b11, 16'hEEDD, 1'b1, 1'b1);
    total++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'hDDCCBBAA, 4'hF, 1'b0}) begin
      bad++; $display("FAIL split_full: got v=%b d=%h k=%h l=%b want v=1 d=ddccbbaa k=f l=0", tvalid, tdata, tkeep, tlast);
    end
    cycle(2'b00, 16'h0, 1'b0, 1'b1);
    total++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h000000EE, 4'h1, 1'b1}) begin
      bad++; $display("FAIL split_rem: got v=%b d=%h k=%h l=%b want v=1 d=000000ee k=1 l=1", tvalid, tdata, tkeep, tlast);
    end
    cycle(2'b00, 16'h0, 1'b0, 1'b1);
    total++;
    if ({tvalid, perr} !== 2'b00) begin bad++; $display("FAIL split_idle: got v=%b perr=%b want 0 0", tvalid, perr); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(2'b01, {8'h00, 8'(i + 1)}, 1'b0, 1'b0);
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    for (int w = 0; w < 4; w++) begin
      exp = '0;
      for (int j = 0; j < 4; j++) exp[8*j +: 8] = 8'(4*w + j + 1);
      total++;
      if ({tvalid, tdata, tkeep, tlast} !== {1'b1, exp, 4'hF, 1'b0}) begin
        bad++; $display("FAIL ovf_drain%0d: got v=%b d=%h k=%h l=%b want v=1 d=%h k=f l=0", w, tvalid, tdata, tkeep, tlast, exp);
      end
      if (w == 0) begin
        cycle(2'b00, 16'h0, 1'b0, 1'b0);
        total++;
        if (tdata !== exp) begin bad++; $display("FAIL ovf_hold: got %h want %h", tdata, exp); end
      end
      cycle(2'b00, 16'h0, 1'b0, 1'b1);
    end
    total++;
    if ({tvalid, ovf} !== 2'b01) begin bad++; $display("FAIL ovf_empty: got v=%b ovf=%b want 0 1", tvalid, ovf); end
  endtask

  task automatic test_empty_flush_perr();
    do_reset();
    cycle(2'b00, 16'h0, 1'b1, 1'b0);
    total++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h0, 4'h0, 1'b1}) begin
      bad++; $display("FAIL empty_flush: got v=%b d=%h k=%h l=%b want v=1 d=0 k=0 l=1", tvalid, tdata, tkeep, tlast);
    end
    cycle(2'b10, 16'h1234, 1'b0, 1'b1);
    total++;
    if ({perr, tvalid} !== 2'b10) begin bad++; $display("FAIL perr_set: got perr=%b v=%b want 1 0", perr, tvalid); end
    cycle(2'b01, 16'h0077, 1'b1, 1'b1);
    total++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h00000077, 4'h1, 1'b1}) begin
      bad++; $display("FAIL perr_no_byte: got v=%b d=%h k=%h l=%b want v=1 d=77 k=1 l=1", tvalid, tdata, tkeep, tlast);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(2'b11, 16'(16'hA0A0 + i), 1'b0, 1'b0);
    cycle(2'b10, 16'h0, 1'b0, 1'b0);
    total++;
    if ({tvalid, perr} !== 2'b11) begin bad++; $display("FAIL mid_setup: got v=%b perr=%b want 1 1", tvalid, perr); end
    do_reset();
    total++;
    if ({tvalid, tdata, tkeep, tlast, ovf, perr} !== 40'h0) begin
      bad++; $display("FAIL mid_reset: got v=%b d=%h k=%h l=%b ovf=%b perr=%b want all zero", tvalid, tdata, tkeep, tlast, ovf, perr);
    end
    cycle(2'b01, 16'h00C3, 1'b1, 1'b1);
    total++;
    if ({tvalid, tdata, tkeep, tlast} !== {1'b1, 32'h000000C3, 4'h1, 1'b1}) begin
      bad++; $display("FAIL mid_lane0: got v=%b d=%h k=%h l=%b want v=1 d=c3 k=1 l=1", tvalid, tdata, tkeep, tlast);
    end
  endtask

  task automatic test_random();
    logic [1:0] v;
    logic       f, prev_f;
    int         r;
    do_reset();
    prev_f = 0;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 31);
      if (prev_f)      v = 2'b00;
      else if (r == 0) v = 2'b10;
      else if (r < 10) v = 2'b00;
      else if (r < 20) v = 2'b01;
      else             v = 2'b11;
      f = !prev_f && ($urandom_range(0, 9) == 0);
      cycle(v, 16'($urandom), f, ($urandom_range(0, 3) != 0));
      prev_f = f;
      total++;
      if (tvalid !== (mq.size() > 0)) begin
        bad++; $display("FAIL rand_valid c%0d: got %b want %b", c, tvalid, (mq.size() > 0));
      end else if (mq.size() > 0) begin
        total++;
        if ({tdata, tkeep, tlast} !== {mq[0].d, mq[0].k, mq[0].l}) begin
          bad++; $display("FAIL rand_head c%0d: got d=%h k=%h l=%b want d=%h k=%h l=%b", c, tdata, tkeep, tlast, mq[0].d, mq[0].k, mq[0].l);
        end
      end
      total++;
      if ({ovf, perr} !== {m_ovf, m_perr}) begin
        bad++; $display("FAIL rand_flags c%0d: got ovf=%b perr=%b want %b %b", c, ovf, perr, m_ovf, m_perr);
      end
    end
  endtask

  initial begin
    rst = 1; valid = 0; enc = 0; flush = 0; tready = 0;
    test_reset();
    test_single_bytes();
    test_pairs();
    test_flush_split();
    test_overflow();
    test_empty_flush_perr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rans_byte_packer.md
RANS_BYTE_PACKER -- requirements
Module: rans_byte_packer

Interface
REQ-001 SHALL have parameter SYMBOL_WIDTH, default 8, giving the byte width emitted by the encoder stage.
REQ-002 SHALL have parameter WORD_BYTES, default 4, giving the bytes per output word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving the output word FIFO depth (power of two, >=2).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port valid_i, input, 2 bits: bit0 means byte0 is valid; bit1 means byte1 is also valid.
REQ-007 SHALL have port enc_i, input, 2*SYMBOL_WIDTH bits: byte0 = [SYMBOL_WIDTH-1:0], byte1 = upper byte.
REQ-008 SHALL have port flush_i, input, 1 bit: end of stream; emit any partial word, marked last.
REQ-009 SHALL have port m_tvalid_o, output, 1 bit: output word valid.
REQ-010 SHALL have port m_tready_i, input, 1 bit: downstream ready.
REQ-011 SHALL have port m_tdata_o, output, WORD_BYTES*SYMBOL_WIDTH bits: packed word, first-received byte in lane 0 (LSBs).
REQ-012 SHALL have port m_tkeep_o, output, WORD_BYTES bits: lane-valid mask, contiguous from lane 0.
REQ-013 SHALL have port m_tlast_o, output, 1 bit: final word of the stream.
REQ-014 SHALL have port overflow_o, output, 1 bit: sticky flag for a dropped word.
REQ-015 SHALL have port protocol_err_o, output, 1 bit: sticky flag for an input-rule violation.

Function
REQ-016 SHALL take 0 bytes for valid_i=00, byte0 for 01, and byte0 then byte1 for 11; valid_i=10 SHALL be treated as 00 and SHALL set protocol_err_o.
REQ-017 SHALL append accepted bytes into the accumulator at lane = fill, fill+1, where fill is in 0..WORD_BYTES-1.
REQ-018 SHALL push a word with keep all ones to the FIFO when fill+n >= WORD_BYTES, carrying the remainder byte into lane 0 with fill = fill+n-WORD_BYTES.
REQ-019 SHALL treat the bytes of the same cycle as preceding flush_i. After those bytes: if fill>0, push the partial word with keep=(1<<fill)-1, unused lanes zero, last=1, and set fill=0.
REQ-020 SHALL, on flush_i, mark last=1 on the word completed that cycle when that word leaves fill=0.
REQ-021 SHALL, on flush_i when no bytes are pending, push a word with keep=0, data=0, last=1.
REQ-022 SHALL, when flush_i requires two pushes (full word plus remainder), push the full word that cycle, set state FLUSH_PEND, and push the remainder word last=1 the next cycle.
REQ-023 SHALL implement states ACCUM and FLUSH_PEND: ACCUM->FLUSH_PEND per REQ-022; FLUSH_PEND->ACCUM unconditionally after one cycle.
REQ-024 SHALL drop any bytes arriving in FLUSH_PEND and set protocol_err_o; upstream SHALL hold valid_i=00 the cycle after flush_i.
REQ-025 SHALL accept a push when the FIFO is not full, or when full with a pop in the same cycle.
REQ-026 SHALL otherwise discard the word and set overflow_o, leaving accumulator state advancing as if it were pushed.
REQ-027 SHALL drive m_t* from the FIFO head; a pop occurs on m_tvalid_o && m_tready_i.
REQ-028 SHALL hold data, keep and last stable while m_tvalid_o && !m_tready_i.
REQ-029 SHALL have a latency of exactly 1 cycle from the completing input cycle to m_tvalid_o when the FIFO is empty.
REQ-030 SHALL provide one-word-per-cycle throughput with no bubbles at m_tready_i=1.
REQ-031 SHALL perform no byte reordering; stream reversal for decoding is outside this block.

Reset
REQ-032 SHALL, on rst_i, clear fill, accumulator, FIFO pointers and count, and both sticky flags, and set state ACCUM.
REQ-033 SHALL drive m_tvalid_o=0, m_tdata_o=0, m_tkeep_o=0 and m_tlast_o=0 from the cycle after reset.
REQ-034 SHALL give rst_i priority over all inputs; a reset mid-stream SHALL discard partial and queued words without emitting them.

Structure
REQ-035 SHALL place SYMBOL_WIDTH, WORD_BYTES, the word and keep typedefs, and the state enum in the shared package rans_pkg.
REQ-036 SHALL implement the FIFO as sub-module rans_word_fifo: synchronous, registered head, full/empty flags, and a {data, keep, last} payload.

Verification
REQ-037 SHALL verify: valid_i=01 with bytes 11,22,33,44 over 4 cycles, tready=1 -> one word 0x44332211, keep=F, last=0, valid 1 cycle after the 4th byte.
REQ-038 SHALL verify: valid_i=11 enc 0x2211 then 0x4433 then 0x6655 -> word 0x44332211, with fill=2 holding 55,66.
REQ-039 SHALL verify: fill=3 (AA,BB,CC), then valid_i=11 enc 0xEEDD with flush_i -> word 0xDDCCBBAA keep=F last=0, then the next cycle 0x000000EE keep=1 last=1.
REQ-040 SHALL verify: tready=0 with 5 full words pushed at depth 4 -> 4 words retained, overflow_o=1, and words drained in order once tready=1.
REQ-041 SHALL verify: flush_i with fill=0 -> keep=0 last=1 word; valid_i=10 -> protocol_err_o=1 with no byte taken.
REQ-042 SHALL verify: rst_i asserted with fill=2 and 2 queued words -> m_tvalid_o=0 next cycle, flags cleared, and new bytes start at lane 0.
